dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: maximum cycles to wait for mem_stall to rise after issue.
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports core_req/dma_req  in  1  requester holds high, with payload stable, until its done pulse.
REQ-005 SHALL have ports core_we/dma_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports core_addr/dma_addr  in  32, core_wdata/dma_wdata  in  32, core_mask/dma_mask  in  4  (sign_mask encoding).
REQ-007 SHALL have ports core_done/dma_done  out  1  one-cycle completion pulse; core_err/dma_err  out  1  valid with done, 1 = timeout.
REQ-008 SHALL have ports core_rdata/dma_rdata  out  32  read result, held until that port's next completion.
REQ-009 SHALL have ports mem_read/mem_write  out  1, mem_addr/mem_wdata  out  32, mem_mask  out  4  (drive data memory).
REQ-010 SHALL have ports mem_rdata  in  32, mem_stall  in  1  (memory read data and stall).

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
REQ-012 IDLE: when any req=1 and mem_stall=0, SHALL latch winner's payload and owner ID and go to ISSUE; with mem_stall=1 SHALL stay in IDLE.
REQ-013 ISSUE: SHALL drive mem_read=~we or mem_write=we for exactly one cycle with latched addr/wdata/mask, then go to WAIT_HI.
REQ-014 WAIT_HI: SHALL go to WAIT_LO on mem_stall=1; SHALL go to RESP with err=1 when TIMEOUT_CYC cycles elapse without it.
REQ-015 WAIT_LO: SHALL go to RESP on first cycle mem_stall=0, capturing mem_rdata into owner's rdata register (reads only).
REQ-016 RESP: SHALL pulse owner's done (and err if timed out) for one cycle, then return to IDLE; non-owner outputs unchanged.
REQ-017 All mem_* and requester outputs SHALL be registered; mem_read/mem_write SHALL be 0 outside ISSUE.
REQ-018 Nominal latency (memory stalls 2 cycles): req sampled in cycle N -> done in cycle N+5; back-to-back issue earliest cycle N+6.
REQ-019 Writes SHALL leave owner's rdata unchanged; a timed-out read SHALL load rdata with 0.
REQ-020 Timeout counter SHALL clear on ISSUE entry and saturate; width ceil(log2(TIMEOUT_CYC+1)).
REQ-021 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, mem_read/mem_write/done/err=0, rdata registers=0, counter=0, priority pointer=core.
REQ-023 Reset mid-transaction SHALL abandon it without done; first post-reset issue SHALL wait for mem_stall=0 (REQ-012).

Configuration
REQ-024 Macro DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests, port not served last wins; pointer updates on RESP.
REQ-025 Macro undefined: fixed priority, core always wins ties; dma can starve (accepted).

Structure
REQ-026 Shared package SHALL hold state encoding, owner-ID constants (OWN_CORE=0, OWN_DMA=1), sign_mask field constants.
REQ-027 One sub-module, dmem_arb_pick (combinational winner select plus registered RR pointer), SHALL hold all priority logic.

Verification
REQ-028 Core read addr 0x100, memory model stalls 2 cycles returning 0xDEADBEEF -> mem_read pulse 1 cycle, core_done at N+5, core_rdata=0xDEADBEEF, core_err=0.
REQ-029 Simultaneous core write 0x10 / dma read 0x20 -> fixed: core served first, dma done 6 cycles later; RR (after a prior core transaction): dma first.
REQ-030 Memory model never stalls -> err=1 with done exactly TIMEOUT_CYC+2 cycles after ISSUE; rdata=0.
REQ-031 rst_n=0 during WAIT_LO with mem_stall=1 held 3 more cycles, pending core_req -> no done, mem_read stays 0 until stall drops, then normal issue.
REQ-032 Continuous dma_req plus core_req every transaction, DMEM_ARB_RR_EN defined -> grants strictly alternate over 8 transactions.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding,
//   owner IDs, sign_mask byte-lane constants and a counter-width helper.
//   Build option: DMEM_ARB_RR_EN (round-robin arbitration, see dmem_arb_pick).

package dmem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    // sign_mask: one enable bit per byte lane, bit i = byte i of the word
    localparam int         SMASK_W       = 4;
    localparam logic [3:0] SMASK_B0      = 4'b0001;
    localparam logic [3:0] SMASK_B1      = 4'b0010;
    localparam logic [3:0] SMASK_B2      = 4'b0100;
    localparam logic [3:0] SMASK_B3      = 4'b1000;
    localparam logic [3:0] SMASK_HALF_LO = 4'b0011;
    localparam logic [3:0] SMASK_HALF_HI = 4'b1100;
    localparam logic [3:0] SMASK_WORD    = 4'b1111;

    // ceil(log2(max_val+1)), never less than 1
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (core, dma) and the data-memory port.
//   slave  : arbiter side (takes requests, drives memory)
//   master : environment side (requesters and memory model)
//   Build option DMEM_ARB_RR_EN does not affect this interface.

interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic               core_req;
    logic               core_we;
    logic [31:0]        core_addr;
    logic [31:0]        core_wdata;
    logic [SMASK_W-1:0] core_mask;
    logic               core_done;
    logic               core_err;
    logic [31:0]        core_rdata;

    logic               dma_req;
    logic               dma_we;
    logic [31:0]        dma_addr;
    logic [31:0]        dma_wdata;
    logic [SMASK_W-1:0] dma_mask;
    logic               dma_done;
    logic               dma_err;
    logic [31:0]        dma_rdata;

    logic               mem_read;
    logic               mem_write;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [SMASK_W-1:0] mem_mask;
    logic [31:0]        mem_rdata;
    logic               mem_stall;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_mask,
        output core_done, core_err, core_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_mask,
        output dma_done, dma_err, dma_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata, mem_stall
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_mask,
        input  core_done, core_err, core_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_mask,
        input  dma_done, dma_err, dma_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_mask,
        output mem_rdata, mem_stall
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Winner select between core and dma, plus the priority pointer.
//   DMEM_ARB_RR_EN defined  : round-robin, the port not served last wins ties;
//                             pointer moves when a response completes.
//   DMEM_ARB_RR_EN undefined: fixed priority, core always wins ties.
//   Ports: clk, rst_n (sync, active-low), core_req_i, dma_req_i,
//          resp_i (transaction in RESP), owner_i (owner of that transaction),
//          grant_o (owner ID of the winner, valid when any request is high).

module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic core_req_i,
    input  logic dma_req_i,
    input  logic resp_i,
    input  logic owner_i,
    output logic grant_o
);

    logic prio_q;
    logic prio_d;

`ifdef DMEM_ARB_RR_EN
    assign prio_d = resp_i ? ~owner_i : prio_q;
`else
    // fixed priority never moves the pointer
    logic unused_served;
    assign unused_served = resp_i ^ owner_i;
    assign prio_d        = OWN_CORE;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) prio_q <= OWN_CORE;
        else        prio_q <= prio_d;
    end

    assign grant_o = (core_req_i && (!dma_req_i || prio_q == OWN_CORE)) ? OWN_CORE : OWN_DMA;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port (core, dma) arbiter in front of a single stalling data memory.
//   One transaction at a time: issue a one-cycle mem_read/mem_write, wait for
//   mem_stall to rise and fall again, then pulse the owner's done.  If stall
//   never rises within TIMEOUT_CYC cycles the owner gets done with err=1.
//   Ports: clk, rst_n (sync, active-low), bus (dmem_arbiter_if.slave).
//   Build option: DMEM_ARB_RR_EN selects round-robin instead of core priority.
//
//   state      | meaning
//   IDLE       | waiting for a request while memory is not stalled
//   ISSUE      | mem_read/mem_write high for this single cycle
//   WAIT_HI    | waiting for mem_stall to rise, timeout counter running
//   WAIT_LO    | waiting for mem_stall to fall, rdata captured on exit
//   RESP       | owner's done (and err) high for one cycle

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam int               CNT_W   = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e   state_q;
    logic         owner_q;
    logic         we_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;
    logic [3:0]   mask_q;
    logic [CNT_W-1:0] cnt_q;
    logic         mem_read_q;
    logic         mem_write_q;
    logic         core_done_q;
    logic         core_err_q;
    logic [31:0]  core_rdata_q;
    logic         dma_done_q;
    logic         dma_err_q;
    logic [31:0]  dma_rdata_q;

    logic         grant;
    logic         any_req;
    logic         sel_we;
    logic [31:0]  sel_addr;
    logic [31:0]  sel_wdata;
    logic [3:0]   sel_mask;
    logic         fin;
    logic         fin_err;
    logic [31:0]  rsp_data;

    dmem_arb_pick u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req_i (bus.core_req),
        .dma_req_i  (bus.dma_req),
        .resp_i     (state_q == ST_RESP),
        .owner_i    (owner_q),
        .grant_o    (grant)
    );

    always_comb begin
        any_req   = bus.core_req | bus.dma_req;
        sel_we    = (grant == OWN_DMA) ? bus.dma_we    : bus.core_we;
        sel_addr  = (grant == OWN_DMA) ? bus.dma_addr  : bus.core_addr;
        sel_wdata = (grant == OWN_DMA) ? bus.dma_wdata : bus.core_wdata;
        sel_mask  = (grant == OWN_DMA) ? bus.dma_mask  : bus.core_mask;

        fin     = 1'b0;
        fin_err = 1'b0;
        if (state_q == ST_WAIT_HI && !bus.mem_stall && cnt_q == CNT_TMO) begin
            fin     = 1'b1;
            fin_err = 1'b1;
        end
        if (state_q == ST_WAIT_LO && !bus.mem_stall) fin = 1'b1;
        // a timed-out read returns zero rather than whatever is on the bus
        rsp_data = fin_err ? 32'h0 : bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CORE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            core_done_q  <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= '0;
            dma_done_q   <= 1'b0;
            dma_err_q    <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            core_done_q <= 1'b0;
            core_err_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_err_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (any_req && !bus.mem_stall) begin
                        owner_q     <= grant;
                        we_q        <= sel_we;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        mask_q      <= sel_mask;
                        cnt_q       <= '0;
                        mem_read_q  <= ~sel_we;
                        mem_write_q <= sel_we;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE:   state_q <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    if (bus.mem_stall)          state_q <= ST_WAIT_LO;
                    else if (fin)               state_q <= ST_RESP;
                    else if (cnt_q != CNT_MAX)  cnt_q   <= cnt_q + 1'b1;
                end
                ST_WAIT_LO: if (fin) state_q <= ST_RESP;
                ST_RESP:    state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase

            if (fin) begin
                if (owner_q == OWN_CORE) begin
                    core_done_q <= 1'b1;
                    core_err_q  <= fin_err;
                    if (!we_q) core_rdata_q <= rsp_data;
                end else begin
                    dma_done_q <= 1'b1;
                    dma_err_q  <= fin_err;
                    if (!we_q) dma_rdata_q <= rsp_data;
                end
            end
        end
    end

    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_mask   = mask_q;
    assign bus.core_done  = core_done_q;
    assign bus.core_err   = core_err_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.dma_done   = dma_done_q;
    assign bus.dma_err    = dma_err_q;
    assign bus.dma_rdata  = dma_rdata_q;

endmodule
